// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_writeback_queue
//  Description : Write-side companion of the register file. Buffers (rd, data)
//                write-back results in a small FIFO and drains them in order to
//                the register file write port, at most one write per cycle.
//                Two combinational forwarding lookups (rs1, rs2) expose the
//                newest pending value for a register before it lands.
//  Ports       : clk, rst            - clock, asynchronous active-high reset
//                in_valid/in_ready   - producer handshake for in_rd/in_data
//                hold                - suspends draining when high
//                regWrite/wr/WD      - registered register-file write port
//                rs1/rs2             - forwarding lookup indices
//                fwd{1,2}_hit/_data  - forwarding results (data 0 on miss)
//                count               - entries queued (output stage excluded)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [AW-1:0]                  in_rd,
  input  logic [DW-1:0]                  in_data,
  input  logic                           hold,
  output logic                           regWrite,
  output logic [AW-1:0]                  wr,
  output logic [DW-1:0]                  WD,
  input  logic [AW-1:0]                  rs1,
  input  logic [AW-1:0]                  rs2,
  output logic                           fwd1_hit,
  output logic [DW-1:0]                  fwd1_data,
  output logic                           fwd2_hit,
  output logic [DW-1:0]                  fwd2_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [DW-1:0] wd_q, wd_d;

  // Queue storage. Validity is derived from head pointer and count, so the
  // contents need no reset: clearing count invalidates every entry.
  logic [AW-1:0] mem_rd_q   [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];

  logic w_push;
  logic w_pop;

  // in_ready looks only at count; a full queue never accepts even when the
  // head is leaving on the same edge.
  assign in_ready = (count_q != CW'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (count_q != '0) && !hold;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    regwrite_d = 1'b0;
    wr_d       = wr_q;
    wd_d       = wd_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (w_pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      regwrite_d = 1'b1;
      wr_d       = mem_rd_q[rd_ptr_q];
      wd_d       = mem_data_q[rd_ptr_q];
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control and output-stage registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      regwrite_q <= 1'b0;
      wr_q       <= '0;
      wd_q       <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      regwrite_q <= regwrite_d;
      wr_q       <= wr_d;
      wd_q       <= wd_d;
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_rd_q[wr_ptr_q]   <= in_rd;
      mem_data_q[wr_ptr_q] <= in_data;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding
  // The output stage is the oldest pending write, so it is considered first;
  // queue entries are then scanned from head (oldest) to tail-1 (newest), and
  // each later match overrides the earlier one so the newest value wins.
  // --------------------------------------------------------------------------
  always_comb begin
    fwd1_hit  = regwrite_q && (wr_q == rs1);
    fwd1_data = (regwrite_q && (wr_q == rs1)) ? wd_q : '0;
    fwd2_hit  = regwrite_q && (wr_q == rs2);
    fwd2_data = (regwrite_q && (wr_q == rs2)) ? wd_q : '0;

    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        if (mem_rd_q[rd_ptr_q + PW'(k)] == rs1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem_data_q[rd_ptr_q + PW'(k)];
        end
        if (mem_rd_q[rd_ptr_q + PW'(k)] == rs2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem_data_q[rd_ptr_q + PW'(k)];
        end
      end
    end
  end

  assign regWrite = regwrite_q;
  assign wr       = wr_q;
  assign WD       = wd_q;
  assign count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_writeback_queue
//  Description : Directed self-checking bench for regfile_writeback_queue
//                (DEPTH=4, AW=5, DW=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic [DW-1:0] in_data;
  logic          hold;
  logic          regWrite;
  logic [AW-1:0] wr;
  logic [DW-1:0] WD;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          fwd1_hit;
  logic [DW-1:0] fwd1_data;
  logic          fwd2_hit;
  logic [DW-1:0] fwd2_data;
  logic [CW-1:0] count;

  int n_cmp  = 0;
  int n_fail = 0;

  regfile_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .hold      (hold),
    .regWrite  (regWrite),
    .wr        (wr),
    .WD        (WD),
    .rs1       (rs1),
    .rs2       (rs2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after
  // the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 0; in_rd = '0; in_data = '0; hold = 0; rs1 = '0; rs2 = '0;
    rst = 1;
    step(); step();
    rst = 0;
    step();
    n_cmp++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regWrite: got %b want 0", regWrite); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (wr !== 5'd0 || WD !== 32'd0) begin n_fail++; $display("FAIL reset_wr_WD: got %0d/%h want 0/0", wr, WD); end
    n_cmp++; if (fwd1_hit !== 1'b0 || fwd1_data !== 32'd0) begin n_fail++; $display("FAIL reset_fwd1: got %b/%h want 0/0", fwd1_hit, fwd1_data); end
  endtask

  // Single entry through an empty queue: visible on the write port one edge
  // after the push, for exactly one cycle.
  task automatic test_single();
    hold = 0; in_valid = 1; in_rd = 5'd3; in_data = 32'hDEADBEEF;
    step();
    in_valid = 0;
    n_cmp++; if (count !== 3'd1 || regWrite !== 1'b0) begin n_fail++; $display("FAIL single_after_push: got count=%0d rw=%b want 1/0", count, regWrite); end
    step();
    n_cmp++; if (regWrite !== 1'b1 || wr !== 5'd3 || WD !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_write: got rw=%b wr=%0d WD=%h want 1/3/deadbeef", regWrite, wr, WD); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d want 0", count); end
    step();
    n_cmp++; if (regWrite !== 1'b0 || wr !== 5'd3 || WD !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_one_cycle: got rw=%b wr=%0d WD=%h want 0/3/deadbeef", regWrite, wr, WD); end
  endtask

  // Fill under hold, try an overflow push, then drain in FIFO order.
  task automatic test_full();
    hold = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_rd = AW'(i); in_data = 32'h100 + DW'(i);
      step();
    end
    n_cmp++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got count=%0d rdy=%b want 4/0", count, in_ready); end
    n_cmp++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL full_hold_no_write: got %b want 0", regWrite); end
    in_valid = 1; in_rd = 5'd9; in_data = 32'h999;
    step();
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_drop: got count=%0d want 4", count); end
    in_valid = 0; hold = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++;
      if (regWrite !== 1'b1 || wr !== AW'(i) || WD !== (32'h100 + DW'(i))) begin
        n_fail++; $display("FAIL full_drain_%0d: got rw=%b wr=%0d WD=%h want 1/%0d/%h", i, regWrite, wr, WD, i, 32'h100 + i);
      end
    end
    step();
    n_cmp++; if (regWrite !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL full_after_drain: got rw=%b count=%0d want 0/0", regWrite, count); end
  endtask

  // Two pending writes to the same register: newest wins; other index misses.
  task automatic test_fwd_queue();
    hold = 1;
    in_valid = 1; in_rd = 5'd5; in_data = 32'd1; step();
    in_valid = 1; in_rd = 5'd5; in_data = 32'd2; step();
    in_valid = 0;
    rs1 = 5'd5; rs2 = 5'd6; #1;
    n_cmp++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'd2) begin n_fail++; $display("FAIL fwd_newest: got %b/%h want 1/2", fwd1_hit, fwd1_data); end
    n_cmp++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'd0) begin n_fail++; $display("FAIL fwd_miss: got %b/%h want 0/0", fwd2_hit, fwd2_data); end
    // Drain: after the first pop the output stage holds 5/1 but the queued
    // 5/2 is newer and must still win.
    hold = 0; step();
    n_cmp++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'd2) begin n_fail++; $display("FAIL fwd_queue_over_stage: got %b/%h want 1/2", fwd1_hit, fwd1_data); end
    step(); step();
  endtask

  // Output stage forwards when regWrite=1 and stops once regWrite drops.
  task automatic test_fwd_stage();
    hold = 0; rs1 = 5'd0; rs2 = 5'd7;
    in_valid = 1; in_rd = 5'd7; in_data = 32'h55; step();
    in_valid = 0;
    n_cmp++; if (fwd2_hit !== 1'b1 || fwd2_data !== 32'h55) begin n_fail++; $display("FAIL fwd_queued_7: got %b/%h want 1/55", fwd2_hit, fwd2_data); end
    step();
    n_cmp++; if (regWrite !== 1'b1 || wr !== 5'd7 || count !== 3'd0) begin n_fail++; $display("FAIL stage_state: got rw=%b wr=%0d count=%0d want 1/7/0", regWrite, wr, count); end
    n_cmp++; if (fwd2_hit !== 1'b1 || fwd2_data !== 32'h55) begin n_fail++; $display("FAIL fwd_stage: got %b/%h want 1/55", fwd2_hit, fwd2_data); end
    n_cmp++; if (fwd1_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_stage_other: got %b want 0", fwd1_hit); end
    step();
    n_cmp++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'd0) begin n_fail++; $display("FAIL fwd_stage_stale: got %b/%h want 0/0", fwd2_hit, fwd2_data); end
  endtask

  // Register 0 is ordinary: queued and forwarded like any other index.
  task automatic test_reg0();
    hold = 1; rs1 = 5'd0;
    in_valid = 1; in_rd = 5'd0; in_data = 32'hABCD; step();
    in_valid = 0;
    n_cmp++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hABCD) begin n_fail++; $display("FAIL fwd_reg0: got %b/%h want 1/abcd", fwd1_hit, fwd1_data); end
    hold = 0; step();
    n_cmp++; if (regWrite !== 1'b1 || wr !== 5'd0 || WD !== 32'hABCD) begin n_fail++; $display("FAIL write_reg0: got rw=%b wr=%0d WD=%h want 1/0/abcd", regWrite, wr, WD); end
    step();
  endtask

  // Simultaneous push and pop with count=2 keeps count and order.
  task automatic test_back_to_back();
    hold = 1;
    in_valid = 1; in_rd = 5'd10; in_data = 32'hA0; step();
    in_valid = 1; in_rd = 5'd11; in_data = 32'hA1; step();
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count_pre: got %0d want 2", count); end
    hold = 0; in_valid = 1; in_rd = 5'd12; in_data = 32'hA2; step();
    in_valid = 0;
    n_cmp++; if (count !== 3'd2 || regWrite !== 1'b1 || wr !== 5'd10 || WD !== 32'hA0) begin n_fail++; $display("FAIL b2b_pushpop: got count=%0d rw=%b wr=%0d WD=%h want 2/1/10/a0", count, regWrite, wr, WD); end
    step();
    n_cmp++; if (regWrite !== 1'b1 || wr !== 5'd11 || WD !== 32'hA1) begin n_fail++; $display("FAIL b2b_second: got rw=%b wr=%0d WD=%h want 1/11/a1", regWrite, wr, WD); end
    step();
    n_cmp++; if (regWrite !== 1'b1 || wr !== 5'd12 || WD !== 32'hA2 || count !== 3'd0) begin n_fail++; $display("FAIL b2b_third: got rw=%b wr=%0d WD=%h count=%0d want 1/12/a2/0", regWrite, wr, WD, count); end
    step();
    n_cmp++; if (regWrite !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", regWrite); end
  endtask

  // Asynchronous reset mid-cycle with entries pending and a write on the port.
  task automatic test_reset_mid();
    hold = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_rd = AW'(16 + i); in_data = 32'hC0 + DW'(i); step();
    end
    in_valid = 0; hold = 0; step();
    n_cmp++; if (count !== 3'd3 || regWrite !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got count=%0d rw=%b want 3/1", count, regWrite); end
    #2 rst = 1;
    #1;
    n_cmp++; if (regWrite !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_async: got rw=%b count=%0d rdy=%b want 0/0/1", regWrite, count, in_ready); end
    n_cmp++; if (wr !== 5'd0 || WD !== 32'd0) begin n_fail++; $display("FAIL rstmid_wr_WD: got %0d/%h want 0/0", wr, WD); end
    step();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (regWrite !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL rstmid_no_write_%0d: got rw=%b count=%0d want 0/0", i, regWrite, count); end
    end
    // Pointers are back at 0: a fresh entry drains normally.
    in_valid = 1; in_rd = 5'd20; in_data = 32'h2020; step();
    in_valid = 0; step();
    n_cmp++; if (regWrite !== 1'b1 || wr !== 5'd20 || WD !== 32'h2020) begin n_fail++; $display("FAIL rstmid_after: got rw=%b wr=%0d WD=%h want 1/20/2020", regWrite, wr, WD); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_fwd_queue();
    test_fwd_stage();
    test_reg0();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
